draw_cmd_sched: RTL and testbench

//  Command scheduler in front of the shape drawing engine. Two requesters (e.g. host

---
 rtl/draw_cmd_sched.sv | 160 ++++++++++++++++
 tb/tb_draw_cmd_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_cmd_sched.sv
// Shape command scheduler: round-robin intake from two requesters into a small
// FIFO, then issues one command at a time to the drawing engine and reports pixel counts.
module draw_cmd_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [1:0]                    req0_shape,
    input  logic [31:0]                   req0_coords,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [1:0]                    req1_shape,
    input  logic [31:0]                   req1_coords,
    output logic                          eng_start,
    output logic [1:0]                    eng_shape,
    output logic [7:0]                    eng_x0,
    output logic [7:0]                    eng_y0,
    output logic [7:0]                    eng_x1,
    output logic [7:0]                    eng_y1,
    input  logic                          eng_pixel_valid,
    input  logic                          eng_done,
    output logic                          cmp_valid,
    output logic                          cmp_src,
    output logic [CNT_W-1:0]              cmp_pixels,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          idle
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    typedef struct packed {
        logic        src;
        logic [1:0]  shape;
        logic [31:0] coords;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RUN, REPORT} state_t;

    state_t           state, state_nxt;
    cmd_t             mem [FIFO_DEPTH];
    cmd_t             acc_cmd, head;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0] count;
    logic             rr;
    logic             grant0, grant1, has_room;
    logic             acc0, acc1, acc_any, push, pop;
    logic             cur_src;
    logic [CNT_W-1:0] pix_cnt, pix_nxt;

    // Priority requester always granted; the other only when the priority one is idle.
    always_comb begin
        grant0   = !rr || !req1_valid;
        grant1   = rr || !req0_valid;
        pop      = (state == IDLE) && (count != '0);
        has_room = (count != LVL_W'(FIFO_DEPTH)) || pop;
    end

    assign req0_ready = !rst && has_room && grant0;
    assign req1_ready = !rst && has_room && grant1;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign acc_any    = acc0 || acc1;

    always_comb begin
        if (acc1) acc_cmd = '{src: 1'b1, shape: req1_shape, coords: req1_coords};
        else      acc_cmd = '{src: 1'b0, shape: req0_shape, coords: req0_coords};
    end

    // Shapes 0 and 3 are consumed here and never reach the FIFO.
    assign push = acc_any && (acc_cmd.shape == 2'd1 || acc_cmd.shape == 2'd2);
    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= acc_cmd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (acc_any) rr <= ~acc_cmd.src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = ISSUE;
            ISSUE:   state_nxt = RUN;
            RUN:     if (eng_done) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        eng_start = (state == ISSUE);
        cmp_valid = (state == REPORT);
    end

    always_comb begin
        pix_nxt = pix_cnt;
        if (eng_pixel_valid && pix_cnt != '1) pix_nxt = pix_cnt + CNT_W'(1);
    end

    // Operands load only on pop, so they stay frozen for the whole engine run.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_shape  <= '0;
            eng_x0     <= '0;
            eng_y0     <= '0;
            eng_x1     <= '0;
            eng_y1     <= '0;
            cur_src    <= 1'b0;
            pix_cnt    <= '0;
            cmp_src    <= 1'b0;
            cmp_pixels <= '0;
        end else begin
            if (pop) begin
                eng_shape <= head.shape;
                eng_x0    <= head.coords[31:24];
                eng_y0    <= head.coords[23:16];
                eng_x1    <= head.coords[15:8];
                eng_y1    <= head.coords[7:0];
                cur_src   <= head.src;
                pix_cnt   <= '0;
            end else if (state == ISSUE || state == RUN) begin
                pix_cnt <= pix_nxt;
            end
            // Done-cycle pixel is folded in via pix_nxt.
            if (state == RUN && eng_done) begin
                cmp_src    <= cur_src;
                cmp_pixels <= pix_nxt;
            end
        end
    end

    assign fifo_level = count;
    assign idle       = (count == '0) && (state == IDLE);

endmodule

// File: tb/tb_draw_cmd_sched.sv
// Scoreboard bench for draw_cmd_sched with a scripted engine stub.
module tb_draw_cmd_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_shape, req1_shape;
    logic [31:0] req0_coords, req1_coords;
    logic        eng_start;
    logic [1:0]  eng_shape;
    logic [7:0]  eng_x0, eng_y0, eng_x1, eng_y1;
    logic        eng_pixel_valid, eng_done;
    logic        cmp_valid, cmp_src;
    logic [15:0] cmp_pixels;
    logic [2:0]  fifo_level;
    logic        idle;

    draw_cmd_sched #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_shape(req0_shape), .req0_coords(req0_coords),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_shape(req1_shape), .req1_coords(req1_coords),
        .eng_start(eng_start), .eng_shape(eng_shape),
        .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_x1(eng_x1), .eng_y1(eng_y1),
        .eng_pixel_valid(eng_pixel_valid), .eng_done(eng_done),
        .cmp_valid(cmp_valid), .cmp_src(cmp_src), .cmp_pixels(cmp_pixels),
        .fifo_level(fifo_level), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] shape; logic [31:0] coords; } iss_t;
    typedef struct { logic src; logic [15:0] pix; } cmp_t;
    typedef struct { int n; int mode; } stb_t;   // mode 0: done after pixels, 1: done with last, 2: hang

    iss_t iss_q[$];
    cmp_t cmp_q[$];
    stb_t stub_q[$];
    int   acc_log[$];
    int   n_checks = 0, n_errors = 0;
    int   cyc = 0, acc_cyc = 0, start_cyc = -1, cmp_seen = 0;
    logic release_one = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int n, input int mode);
        if (mode == 2) return 16'd0;
        if (n > 65535) return 16'hFFFF;
        return 16'(n);
    endfunction

    // Monitor: compares issued operands and completion reports against the queues.
    iss_t ei;
    cmp_t ec;
    always @(negedge clk) begin
        if (!rst) begin
            if (eng_start) begin
                start_cyc = cyc;
                if (iss_q.size() == 0) check("unexpected_start", 32'(eng_start), 32'd0);
                else begin
                    ei = iss_q.pop_front();
                    check("eng_shape", 32'(eng_shape), 32'(ei.shape));
                    check("eng_coords", {eng_x0, eng_y0, eng_x1, eng_y1}, ei.coords);
                end
            end
            if (cmp_valid) begin
                cmp_seen++;
                if (cmp_q.size() == 0) check("unexpected_cmp", 32'(cmp_valid), 32'd0);
                else begin
                    ec = cmp_q.pop_front();
                    check("cmp_src", 32'(cmp_src), 32'(ec.src));
                    check("cmp_pixels", 32'(cmp_pixels), 32'(ec.pix));
                end
            end
        end
    end

    task automatic run_stub(input int n, input int mode);
        bit ab = 1'b0;
        for (int i = 0; i < n && !ab; i++) begin
            eng_pixel_valid = 1'b1;
            eng_done = (mode == 1 && i == n - 1);
            @(negedge clk);
            if (rst) ab = 1'b1;
        end
        eng_pixel_valid = 1'b0;
        eng_done = 1'b0;
        if (!ab && mode == 0) begin
            eng_done = 1'b1;
            @(negedge clk);
            eng_done = 1'b0;
        end
        if (!ab && mode == 2) begin
            for (int w = 0; w < 5000 && !release_one && !rst; w++) @(negedge clk);
            if (release_one && !rst) begin
                eng_done = 1'b1;
                release_one = 1'b0;
                @(negedge clk);
                eng_done = 1'b0;
            end
        end
    endtask

    // Engine stub, scripted per command through stub_q.
    stb_t st;
    initial begin
        eng_pixel_valid = 1'b0;
        eng_done = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_start && !rst) begin
                if (stub_q.size() == 0) check("stub_underflow", 32'(eng_start), 32'd0);
                else begin
                    st = stub_q.pop_front();
                    run_stub(st.n, st.mode);
                end
            end
        end
    end

    task automatic submit(input int p, input logic [1:0] shape, input logic [31:0] coords,
                          input int n, input int mode);
        bit   acc = 1'b0;
        logic rdy;
        if (p == 0) begin req0_valid = 1'b1; req0_shape = shape; req0_coords = coords; end
        else        begin req1_valid = 1'b1; req1_shape = shape; req1_coords = coords; end
        for (int c = 0; c < 200 && !acc; c++) begin
            #1;
            rdy = (p == 0) ? req0_ready : req1_ready;
            if (rdy) begin
                acc = 1'b1;
                acc_cyc = cyc;
                acc_log.push_back(p);
                if (shape == 2'd1 || shape == 2'd2) begin
                    iss_q.push_back('{shape, coords});
                    cmp_q.push_back('{1'(p), exp_pix(n, mode)});
                    stub_q.push_back('{n, mode});
                end
            end
            @(negedge clk);
        end
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
        check("submit_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        bit ok = 1'b0;
        for (int c = 0; c < bound && !ok; c++) begin
            @(negedge clk);
            #1;
            if (idle && cmp_q.size() == 0 && stub_q.size() == 0) ok = 1'b1;
        end
        check("wait_idle", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        iss_q.delete();
        cmp_q.delete();
        stub_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int cmp0, cmp_during;
    int exp_order[4] = '{0, 1, 0, 1};

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_shape = '0; req0_coords = '0;
        req1_valid = 1'b0; req1_shape = '0; req1_coords = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_start", 32'(eng_start), 32'd0);
        check("rst_cmp", 32'(cmp_valid), 32'd0);
        check("rst_operands", {eng_x0, eng_y0, eng_x1, eng_y1}, 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd1);
        @(negedge clk);

        // T2: single rect, start latency and pixel count
        start_cyc = -1;
        submit(0, 2'd1, {8'd10, 8'd10, 8'd13, 8'd12}, 10, 0);
        for (int c = 0; c < 20 && start_cyc < 0; c++) @(negedge clk);
        check("start_latency", 32'(start_cyc - acc_cyc), 32'd2);
        wait_idle(100);

        // T3: both requesters valid every cycle, rr alternates from 0
        do_reset();
        acc_log.delete();
        fork
            begin
                submit(0, 2'd2, 32'h01020304, 1, 0);
                submit(0, 2'd1, 32'h05060708, 2, 0);
            end
            begin
                submit(1, 2'd1, 32'h11121314, 3, 1);
                submit(1, 2'd2, 32'h15161718, 1, 0);
            end
        join
        check("t3_accepts", 32'(acc_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++)
            check("t3_order", 32'(acc_log[i]), 32'(exp_order[i]));
        wait_idle(200);

        // T5: discarded shape 0/3 between two lines
        cmp0 = cmp_seen;
        submit(0, 2'd2, 32'h20212223, 3, 0);
        wait_idle(100);
        submit(1, 2'd0, 32'hDEADBEEF, 0, 0);
        #1;
        check("t5_level_shape0", 32'(fifo_level), 32'd0);
        check("t5_idle_shape0", 32'(idle), 32'd1);
        submit(1, 2'd3, 32'hCAFEF00D, 0, 0);
        #1;
        check("t5_level_shape3", 32'(fifo_level), 32'd0);
        submit(0, 2'd2, 32'h30313233, 4, 0);
        wait_idle(100);
        check("t5_cmp_count", 32'(cmp_seen - cmp0), 32'd2);

        // T6: saturation and pixel coincident with done
        submit(0, 2'd1, 32'h40414243, 65540, 0);
        wait_idle(70000);
        submit(1, 2'd2, 32'h50515253, 5, 1);
        wait_idle(100);

        // T4: engine hangs; fill FIFO behind one in-flight command
        for (int i = 0; i < 5; i++) submit(0, 2'd1, 32'h60000000 + 32'(i), 0, 2);
        repeat (3) @(negedge clk);
        #1;
        check("t4_level_full", 32'(fifo_level), 32'd4);
        check("t4_ready_full", 32'(req0_ready), 32'd0);
        check("t4_not_idle", 32'(idle), 32'd0);
        release_one = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("t4_level_after_done", 32'(fifo_level), 32'd3);
        check("t4_ready_after_done", 32'(req0_ready), 32'd1);

        // T1: reset mid-RUN with 3 queued
        cmp_during = 0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("t1_level", 32'(fifo_level), 32'd0);
        check("t1_idle", 32'(idle), 32'd1);
        check("t1_start", 32'(eng_start), 32'd0);
        check("t1_cmp", 32'(cmp_valid), 32'd0);
        @(negedge clk);
        iss_q.delete();
        cmp_q.delete();
        stub_q.delete();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (cmp_valid || eng_start) cmp_during++;
        end
        check("t1_quiet_after_reset", 32'(cmp_during), 32'd0);
        check("t1_idle_after", 32'(idle), 32'd1);

        check("cmp_q_drained", 32'(cmp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
